idecode_stage: RTL and testbench
================================

// Module: idecode_stage
// PURPOSE
//  RV32I decode (ID) stage of the 5-stage pipeline; directly downstream of ifetch.
//  Consumes InstrD/PCD/PCPlus4D, decodes control, reads the register file, extends immediates.
//  Registers the result into the ID/EX pipeline register.
//  Accepts writeback (W) for the register file and FlushE from the hazard unit.
// PARAMETERS
//  XLEN      32  datapath width
//  NREGS     32  architectural registers; x0 hardwired to 0
// PORTS
//  clk          in   1     rising-edge clock; the only clock
//  reset        in   1     asynchronous, active-low (0 = reset)
//  InstrD       in   32    instruction from ifetch
//  PCD          in   32    PC of InstrD
//  PCPlus4D     in   32    PCD+4
//  FlushE       in   1     load a bubble into ID/EX next edge
//  RegWriteW    in   1     writeback enable
//  RdW          in   5     writeback destination
//  ResultW      in   32    writeback data
//  Rs1D,Rs2D    out  5     combinational source fields, to hazard unit
//  RegWriteE    out  1     | registered control
//  ResultSrcE   out  2     | 00 ALU, 01 mem, 10 PC+4
//  MemWriteE    out  1     |
//  JumpE        out  1     |
//  BranchE      out  1     |
//  ALUControlE  out  3     | 000 add, 001 sub, 010 and, 011 or, 101 slt
//  ALUSrcE      out  1     | 1 = ImmExt operand
//  IllegalE     out  1     | unsupported opcode flag
//  RD1E,RD2E    out  32    registered operands
//  Rs1E,Rs2E,RdE out 5     registered register fields
//  ImmExtE      out  32    registered sign-extended immediate
//  PCE,PCPlus4E out  32    registered PC values
// BEHAVIOUR
//  Reset (reset=0, async): every *E output = 0; all registers x1..x31 = 0.
//  Latency: one cycle, InstrD at edge N -> *E valid after edge N+1. No stall input.
//  Decode, opcode -> controls (ImmSrc 00 I, 01 S, 10 B, 11 J):
//   0000011 lw : RegWrite, ALUSrc, ResultSrc=01, ImmSrc=I, add
//   0100011 sw : MemWrite, ALUSrc, ImmSrc=S, add
//   0110011 R  : RegWrite, ALU op from funct3/funct7[5]
//   0010011 I  : RegWrite, ALUSrc, ImmSrc=I, op from funct3 (addi ignores funct7)
//   1100011 beq: Branch, ImmSrc=B, sub
//   1101111 jal: RegWrite, Jump, ResultSrc=10, ImmSrc=J
//   other      : all controls 0, IllegalE=1 (architectural no-op)
//   ALU op (R/I): sub only for R with funct3=000, funct7[5]=1; unsupported funct3 -> add
//  Immediates: I={20{i[31]},i[31:20]}; S uses i[31:25],i[11:7];
//   B, J standard RV32I with bit0=0; all sign-extended from i[31].
//  Register file: 2 async reads, 1 sync write on rising clk.
//   Write only when RegWriteW && RdW!=0; x0 reads 0 always.
//   Write-through bypass: RegWriteW && RdW==RsxD && RdW!=0 -> RDx = ResultW (same cycle).
//  FlushE=1 at edge: all control outs incl. IllegalE = 0; data/field outs don't-care (implement as 0).
//  Flush wins over decode. Regfile write still occurs in a flush cycle.
//  Reset mid-operation clears ID/EX and regfile immediately, without waiting for clk.
// STRUCTURE
//  riscv_pkg: opcode constants, ALUControl/ResultSrc/ImmSrc enums, ID/EX control struct.
//  Sub-module regfile_2r1w: async reset, bypass, x0 rule.
//  Decoder and immediate extender stay in this module.
//  ID/EX register: one always_ff, negedge reset.
// TESTING
//  1 reset=0 mid-run -> all *E = 0 in same time step; read x5 -> 0
//  2 W: x5=0x1234 then InstrD=0x00528313 (addi x6,x5,5)
//    -> RD1E=0x1234, ImmExtE=5, ALUSrcE=1, RegWriteE=1, RdE=6
//  3 Same-cycle W: RdW=7, ResultW=0xCAFE with Rs1D=7 -> RD1E=0xCAFE next edge
//  4 RdW=0, ResultW=0xFFFF -> later read of x0 = 0
//  5 sw x2,-4(x1) (0xFE20AE23) -> MemWriteE=1, ImmExtE=0xFFFFFFFC
//    beq back -8 -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8
//  6 FlushE=1 with valid R-type; opcode 0x7F
//    -> flushed cycle has all controls 0; 0x7F gives IllegalE=1, RegWriteE=0

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, control encodings, the ID/EX control
// bundle and the immediate extender used by the decode stage.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int REGW  = 5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } aluCtrl_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } resultSrc_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immSrc_t;

    typedef struct packed {
        logic       regWrite;
        resultSrc_t resultSrc;
        logic       memWrite;
        logic       jump;
        logic       branch;
        aluCtrl_t   aluControl;
        logic       aluSrc;
        logic       illegal;
    } idExCtrl_t;

    // All formats sign-extend from instr[31]; B and J offsets are halfword aligned.
    function automatic logic [XLEN-1:0] extendImm(input logic [31:0] instr,
                                                  input immSrc_t immSrc);
        logic [XLEN-1:0] imm;
        unique case (immSrc)
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two asynchronous reads, one synchronous write,
// x0 hardwired to zero, and write-through bypass so ID sees same-cycle writeback.
module regfile_2r1w
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] ra1,
    input  logic [REGW-1:0] ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [REGW-1:0] wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [0:NREGS-1];
    logic            writeValid;

    assign writeValid = we && (wa != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeValid) begin
            regs[wa] <= wd;
        end
    end

    // x0 never bypasses, so a discarded write to x0 cannot leak into a read.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != '0) rd1 = (writeValid && wa == ra1) ? wd : regs[ra1];
        if (ra2 != '0) rd2 = (writeValid && wa == ra2) ? wd : regs[ra2];
    end

endmodule

// File: rtl/idecode_stage.sv
// RV32I decode stage: control decode, register read, immediate extension and
// the ID/EX pipeline register (flushable to a bubble by the hazard unit).
module idecode_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [REGW-1:0] RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [REGW-1:0] Rs1D,
    output logic [REGW-1:0] Rs2D,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic            IllegalE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic [REGW-1:0] RdE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [REGW-1:0] rdD;
    logic [XLEN-1:0] rd1D, rd2D, immExtD;
    immSrc_t         immSrcD;
    idExCtrl_t       ctrlD, ctrlE;
    aluCtrl_t        aluOpD;

    assign opcode   = InstrD[6:0];
    assign rdD      = InstrD[11:7];
    assign funct3   = InstrD[14:12];
    assign Rs1D     = InstrD[19:15];
    assign Rs2D     = InstrD[24:20];
    assign funct7b5 = InstrD[30];

    regfile_2r1w uRegfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (Rs1D),
        .ra2   (Rs2D),
        .rd1   (rd1D),
        .rd2   (rd2D),
        .we    (RegWriteW),
        .wa    (RdW),
        .wd    (ResultW)
    );

    // Shared R/I ALU op; funct7[5] only selects sub for R-type, so addi with imm[10] set stays add.
    always_comb begin
        aluOpD = ALU_ADD;
        unique case (funct3)
            3'b000:  aluOpD = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  aluOpD = ALU_SLT;
            3'b110:  aluOpD = ALU_OR;
            3'b111:  aluOpD = ALU_AND;
            default: aluOpD = ALU_ADD;
        endcase
    end

    always_comb begin
        ctrlD   = '0;
        immSrcD = IMM_I;
        unique case (opcode)
            OP_LOAD: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.aluSrc    = 1'b1;
                ctrlD.resultSrc = RES_MEM;
            end
            OP_STORE: begin
                ctrlD.memWrite = 1'b1;
                ctrlD.aluSrc   = 1'b1;
                immSrcD        = IMM_S;
            end
            OP_RTYPE: begin
                ctrlD.regWrite   = 1'b1;
                ctrlD.aluControl = aluOpD;
            end
            OP_ITYPE: begin
                ctrlD.regWrite   = 1'b1;
                ctrlD.aluSrc     = 1'b1;
                ctrlD.aluControl = aluOpD;
            end
            OP_BRANCH: begin
                ctrlD.branch     = 1'b1;
                ctrlD.aluControl = ALU_SUB;
                immSrcD          = IMM_B;
            end
            OP_JAL: begin
                ctrlD.regWrite  = 1'b1;
                ctrlD.jump      = 1'b1;
                ctrlD.resultSrc = RES_PC4;
                immSrcD         = IMM_J;
            end
            default: ctrlD.illegal = 1'b1;
        endcase
    end

    assign immExtD = extendImm(InstrD, immSrcD);

    // A flush loads a full bubble; data fields are cleared too so the bubble is deterministic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrlE    <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            ImmExtE  <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
        end else if (FlushE) begin
            ctrlE    <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
            ImmExtE  <= '0;
            PCE      <= '0;
            PCPlus4E <= '0;
        end else begin
            ctrlE    <= ctrlD;
            RD1E     <= rd1D;
            RD2E     <= rd2D;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= rdD;
            ImmExtE  <= immExtD;
            PCE      <= PCD;
            PCPlus4E <= PCPlus4D;
        end
    end

    assign RegWriteE   = ctrlE.regWrite;
    assign ResultSrcE  = ctrlE.resultSrc;
    assign MemWriteE   = ctrlE.memWrite;
    assign JumpE       = ctrlE.jump;
    assign BranchE     = ctrlE.branch;
    assign ALUControlE = ctrlE.aluControl;
    assign ALUSrcE     = ctrlE.aluSrc;
    assign IllegalE    = ctrlE.illegal;

endmodule

// File: tb/tb_idecode_stage.sv
// Directed self-checking bench for idecode_stage: reset, regfile/bypass, decode
// of each supported opcode, flush and asynchronous mid-run reset.
module tb_idecode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        FlushE;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [4:0]  Rs1D, Rs2D;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;

    int assertCount = 0;
    int failCount   = 0;

    logic [10:0]  ctlE;
    logic [185:0] allE;

    assign ctlE = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, IllegalE};
    assign allE = {ctlE, RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE, PCE, PCPlus4E};

    idecode_stage dut (
        .clk         (clk),
        .reset       (reset),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .FlushE      (FlushE),
        .RegWriteW   (RegWriteW),
        .RdW         (RdW),
        .ResultW     (ResultW),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RegWriteE   (RegWriteE),
        .ResultSrcE  (ResultSrcE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .IllegalE    (IllegalE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .ImmExtE     (ImmExtE),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E)
    );

    always #5 clk = ~clk;

    task automatic driveInstr(input logic [31:0] instr, input logic [31:0] pc);
        InstrD   = instr;
        PCD      = pc;
        PCPlus4D = pc + 32'd4;
    endtask

    task automatic driveWb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        RegWriteW = we;
        RdW       = rd;
        ResultW   = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        FlushE = 1'b0;
        driveWb(1'b0, 5'd0, 32'd0);
        driveInstr(32'h00C0A183, 32'h0000_0040);
        tick();
        assertCount++;
        if (allE !== '0) begin
            failCount++;
            $display("FAIL reset_outputs: got %h required 0", allE);
        end
        reset = 1'b1;
    endtask

    task automatic test_regfile_write();
        driveWb(1'b1, 5'd5, 32'h0000_1234);
        driveInstr(32'h00000013, 32'h0000_00FC);
        tick();
        driveWb(1'b0, 5'd0, 32'd0);
        driveInstr(32'h00528313, 32'h0000_0100);
        #1;
        assertCount++;
        if ({Rs1D, Rs2D} !== {5'd5, 5'd5}) begin
            failCount++;
            $display("FAIL rs_fields_comb: got %h/%h required 5/5", Rs1D, Rs2D);
        end
        tick();
        assertCount++;
        if (RD1E !== 32'h1234) begin
            failCount++;
            $display("FAIL addi_rd1: got %h required 00001234", RD1E);
        end
        assertCount++;
        if ({ImmExtE, ALUSrcE, RegWriteE, RdE} !== {32'd5, 1'b1, 1'b1, 5'd6}) begin
            failCount++;
            $display("FAIL addi_fields: got imm=%h alusrc=%b rw=%b rd=%0d required imm=5 alusrc=1 rw=1 rd=6",
                     ImmExtE, ALUSrcE, RegWriteE, RdE);
        end
        assertCount++;
        if ({PCE, PCPlus4E} !== {32'h100, 32'h104}) begin
            failCount++;
            $display("FAIL addi_pc: got %h/%h required 00000100/00000104", PCE, PCPlus4E);
        end
    endtask

    task automatic test_same_cycle_bypass();
        driveWb(1'b1, 5'd7, 32'h0000_CAFE);
        driveInstr(32'h00038413, 32'h0000_0200);
        tick();
        assertCount++;
        if (RD1E !== 32'hCAFE) begin
            failCount++;
            $display("FAIL bypass_rd1: got %h required 0000cafe", RD1E);
        end
        driveWb(1'b0, 5'd0, 32'd0);
        tick();
        assertCount++;
        if (RD1E !== 32'hCAFE) begin
            failCount++;
            $display("FAIL bypass_stored: got %h required 0000cafe", RD1E);
        end
    endtask

    task automatic test_x0();
        driveWb(1'b1, 5'd0, 32'h0000_FFFF);
        driveInstr(32'h00100493, 32'h0000_0300);
        tick();
        assertCount++;
        if ({RD1E, ImmExtE} !== {32'd0, 32'd1}) begin
            failCount++;
            $display("FAIL x0_same_cycle: got rd1=%h imm=%h required 0/1", RD1E, ImmExtE);
        end
        driveWb(1'b0, 5'd0, 32'd0);
        tick();
        assertCount++;
        if (RD1E !== 32'd0) begin
            failCount++;
            $display("FAIL x0_later: got %h required 0", RD1E);
        end
    endtask

    // ctl = {RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc, Illegal}
    task automatic test_decode();
        logic [31:0] instrs [9];
        logic [10:0] ctls   [9];
        logic [31:0] imms   [9];
        logic        immChk [9];
        instrs[0] = 32'h00C0A183; ctls[0] = 11'b1_01_0_0_0_000_1_0; imms[0] = 32'd12;         immChk[0] = 1'b1;
        instrs[1] = 32'hFE20AE23; ctls[1] = 11'b0_00_1_0_0_000_1_0; imms[1] = 32'hFFFFFFFC;   immChk[1] = 1'b1;
        instrs[2] = 32'hFE208CE3; ctls[2] = 11'b0_00_0_0_1_001_0_0; imms[2] = 32'hFFFFFFF8;   immChk[2] = 1'b1;
        instrs[3] = 32'h008000EF; ctls[3] = 11'b1_10_0_1_0_000_0_0; imms[3] = 32'd8;          immChk[3] = 1'b1;
        instrs[4] = 32'h40208533; ctls[4] = 11'b1_00_0_0_0_001_0_0; imms[4] = 32'd0;          immChk[4] = 1'b0;
        instrs[5] = 32'h0020F533; ctls[5] = 11'b1_00_0_0_0_010_0_0; imms[5] = 32'd0;          immChk[5] = 1'b0;
        instrs[6] = 32'h0020A2B3; ctls[6] = 11'b1_00_0_0_0_101_0_0; imms[6] = 32'd0;          immChk[6] = 1'b0;
        instrs[7] = 32'h40000093; ctls[7] = 11'b1_00_0_0_0_000_1_0; imms[7] = 32'h400;        immChk[7] = 1'b1;
        instrs[8] = 32'h0000007F; ctls[8] = 11'b0_00_0_0_0_000_0_1; imms[8] = 32'd0;          immChk[8] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            driveInstr(instrs[i], 32'h0000_1000 + 32'(i * 4));
            tick();
            assertCount++;
            if (ctlE !== ctls[i]) begin
                failCount++;
                $display("FAIL decode_ctl[%0d]: got %b required %b", i, ctlE, ctls[i]);
            end
            if (immChk[i]) begin
                assertCount++;
                if (ImmExtE !== imms[i]) begin
                    failCount++;
                    $display("FAIL decode_imm[%0d]: got %h required %h", i, ImmExtE, imms[i]);
                end
            end
            assertCount++;
            if (PCE !== 32'h0000_1000 + 32'(i * 4)) begin
                failCount++;
                $display("FAIL decode_pc[%0d]: got %h required %h", i, PCE, 32'h0000_1000 + 32'(i * 4));
            end
        end
        driveInstr(32'hFE20AE23, 32'h0000_1100);
        tick();
        assertCount++;
        if ({Rs1E, Rs2E} !== {5'd1, 5'd2}) begin
            failCount++;
            $display("FAIL sw_fields: got rs1=%0d rs2=%0d required 1/2", Rs1E, Rs2E);
        end
    endtask

    task automatic test_flush();
        FlushE = 1'b1;
        driveWb(1'b1, 5'd11, 32'h0000_0055);
        driveInstr(32'h40208533, 32'h0000_2000);
        tick();
        assertCount++;
        if (ctlE !== 11'd0) begin
            failCount++;
            $display("FAIL flush_rtype_ctl: got %b required 0", ctlE);
        end
        driveWb(1'b0, 5'd0, 32'd0);
        driveInstr(32'h0000007F, 32'h0000_2004);
        tick();
        assertCount++;
        if (ctlE !== 11'd0) begin
            failCount++;
            $display("FAIL flush_illegal_ctl: got %b required 0", ctlE);
        end
        FlushE = 1'b0;
        driveInstr(32'h00058633, 32'h0000_2008);
        tick();
        assertCount++;
        if ({RD1E, RdE, RegWriteE} !== {32'h55, 5'd12, 1'b1}) begin
            failCount++;
            $display("FAIL flush_wb_kept: got rd1=%h rd=%0d rw=%b required 00000055/12/1", RD1E, RdE, RegWriteE);
        end
    endtask

    task automatic test_reset_midrun();
        driveInstr(32'h00528313, 32'h0000_3000);
        tick();
        assertCount++;
        if (RD1E !== 32'h1234) begin
            failCount++;
            $display("FAIL pre_reset_x5: got %h required 00001234", RD1E);
        end
        #2;
        reset = 1'b0;
        #1;
        assertCount++;
        if (allE !== '0) begin
            failCount++;
            $display("FAIL async_reset_outputs: got %h required 0", allE);
        end
        tick();
        reset = 1'b1;
        driveInstr(32'h00528313, 32'h0000_3004);
        tick();
        assertCount++;
        if ({RD1E, RdE} !== {32'd0, 5'd6}) begin
            failCount++;
            $display("FAIL post_reset_x5: got rd1=%h rd=%0d required 0/6", RD1E, RdE);
        end
    endtask

    initial begin
        test_reset();
        test_regfile_write();
        test_same_cycle_bypass();
        test_x0();
        test_decode();
        test_flush();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
